// File: rtl/ultrasound_scan_scheduler.sv
// Scan sequencer for the ultrasound location calculator: periodic/on-demand launches,
// per-attempt watchdog with calculator reset and bounded retries, and a held location register.
module ultrasound_scan_scheduler #(
    parameter int SCAN_PERIOD    = 13_500_000,
    parameter int TIMEOUT_CYCLES = 540_000_000,
    parameter int RESET_HOLD     = 2,
    parameter int MAX_RETRIES    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        scan_request,
    input  logic        calc_done,
    input  logic [11:0] calc_location,
    output logic        calc_start,
    output logic        calc_reset,
    output logic [11:0] location,
    output logic        location_valid,
    output logic        location_new,
    output logic        target_lost,
    output logic        timeout_error,
    output logic        busy,
    output logic [7:0]  scan_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        RECOVER   = 2'd2
    } state_t;

    localparam logic [24:0] PERIOD_LAST  = 25'(SCAN_PERIOD - 1);
    localparam logic [29:0] TIMEOUT_LAST = 30'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  HOLD_LAST    = 4'(RESET_HOLD - 1);
    localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [24:0] period_cnt, period_d;
    logic [29:0] wd_cnt, wd_d;
    logic [3:0]  hold_cnt, hold_d;
    logic [1:0]  retry_cnt, retry_d;
    logic        pending, pending_d;
    logic        start_d, reset_d, valid_d, new_d, lost_d, terr_d, busy_d;
    logic [11:0] loc_d;
    logic [7:0]  count_d;

    assign state = state_q;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d   = state_q;
        period_d  = period_cnt;
        wd_d      = wd_cnt;
        hold_d    = hold_cnt;
        retry_d   = retry_cnt;
        pending_d = pending | scan_request;
        start_d   = 1'b0;
        reset_d   = 1'b0;
        loc_d     = location;
        valid_d   = location_valid;
        new_d     = 1'b0;
        lost_d    = target_lost;
        terr_d    = timeout_error;
        count_d   = scan_count;

        unique case (state_q)
            IDLE: begin
                // Request and period expiry in the same cycle launch a single scan.
                if (pending || scan_request || (enable && period_cnt == PERIOD_LAST)) begin
                    state_d   = WAIT_DONE;
                    start_d   = 1'b1;
                    wd_d      = '0;
                    period_d  = '0;
                    retry_d   = '0;
                    pending_d = 1'b0;
                end else if (enable) begin
                    period_d = period_cnt + 1'b1;
                end else begin
                    period_d = '0;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_cnt + 1'b1;
                if (calc_done) begin
                    state_d = IDLE;
                    count_d = scan_count + 1'b1;
                    terr_d  = 1'b0;
                    if (calc_location[7:0] != 8'd0) begin
                        loc_d   = calc_location;
                        valid_d = 1'b1;
                        new_d   = 1'b1;
                        lost_d  = 1'b0;
                    end else begin
                        lost_d = 1'b1;
                    end
                end else if (wd_cnt == TIMEOUT_LAST) begin
                    reset_d = 1'b1;
                    hold_d  = '0;
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                hold_d  = hold_cnt + 1'b1;
                reset_d = 1'b1;
                // The retry start coincides with calc_reset falling.
                if (hold_cnt == HOLD_LAST) begin
                    reset_d = 1'b0;
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_d = retry_cnt + 1'b1;
                        start_d = 1'b1;
                        wd_d    = '0;
                        state_d = WAIT_DONE;
                    end else begin
                        terr_d  = 1'b1;
                        count_d = scan_count + 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed by the combinational block above.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            period_cnt     <= '0;
            wd_cnt         <= '0;
            hold_cnt       <= '0;
            retry_cnt      <= '0;
            pending        <= 1'b0;
            calc_start     <= 1'b0;
            calc_reset     <= 1'b1;
            location       <= '0;
            location_valid <= 1'b0;
            location_new   <= 1'b0;
            target_lost    <= 1'b0;
            timeout_error  <= 1'b0;
            busy           <= 1'b0;
            scan_count     <= '0;
        end else begin
            state_q        <= state_d;
            period_cnt     <= period_d;
            wd_cnt         <= wd_d;
            hold_cnt       <= hold_d;
            retry_cnt      <= retry_d;
            pending        <= pending_d;
            calc_start     <= start_d;
            calc_reset     <= reset_d;
            location       <= loc_d;
            location_valid <= valid_d;
            location_new   <= new_d;
            target_lost    <= lost_d;
            timeout_error  <= terr_d;
            busy           <= busy_d;
            scan_count     <= count_d;
        end
    end

endmodule
